// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: I-side client, D-side client and the shared RAM port.
// slave  = arbiter side, master = the clients and the RAM surrounding it.
interface mem_arbiter_if;
    // I-side (read-only) client
    logic        i_req;
    logic [13:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;
    // D-side (read/write) client
    logic        d_req;
    logic        d_wen;
    logic [13:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    // Shared RAM port (ramstate_t: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
    logic        ram_ren;
    logic        ram_wen;
    logic [15:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic [1:0]  ram_state;

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, ram_load, ram_state,
        output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
               ram_ren, ram_wen, ram_addr, ram_store
    );

    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, ram_load, ram_state,
        input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
               ram_ren, ram_wen, ram_addr, ram_store
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the I-side fetch client and the D-side LSQ client.
// A grant is held until the RAM reports ACCESS/ERROR or the timeout counter expires; the
// winner then gets a one-cycle ack/err pulse with registered read data.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking (default: D-side priority).
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value during the last permitted FREE/BUSY grant cycle.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_d_q, last_d_d;     // 1 = last grant went to D-side
    logic             lat_wen_q, lat_wen_d;
    logic [13:0]      lat_addr_q, lat_addr_d;
    logic [31:0]      lat_wdata_q, lat_wdata_d;
    logic             i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic             d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [31:0]      i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    logic i_elig, d_elig, pick_i, pick_d, granted, is_d;

    // Arbitration, grant tracking, completion/timeout detection and response generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        lat_wen_d   = lat_wen_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        i_rdata_d   = '0;
        d_rdata_d   = '0;

        // A side being answered this cycle still holds req; mask it so it is not re-granted.
        i_elig = bus.i_req & ~(i_ack_q | i_err_q);
        d_elig = bus.d_req & ~(d_ack_q | d_err_q);
`ifdef MEM_ARB_RR_EN
        pick_d = d_elig & (~i_elig | ~last_d_q);
`else
        pick_d = d_elig;
`endif
        pick_i = i_elig & ~pick_d;
        is_d   = (state_q == GRANT_D);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_d) begin
                    state_d     = GRANT_D;
                    last_d_d    = 1'b1;
                    lat_wen_d   = bus.d_wen;
                    lat_addr_d  = bus.d_addr;
                    lat_wdata_d = bus.d_wdata;
                end else if (pick_i) begin
                    state_d     = GRANT_I;
                    last_d_d    = 1'b0;
                    lat_wen_d   = 1'b0;
                    lat_addr_d  = bus.i_addr;
                    lat_wdata_d = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.ram_state == RS_ACCESS) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (is_d) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = lat_wen_q ? 32'd0 : bus.ram_load;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.ram_load;
                    end
                end else if (bus.ram_state == RS_ERROR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    d_err_d = is_d;
                    i_err_d = ~is_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        d_err_d = is_d;
                        i_err_d = ~is_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers; reset returns to IDLE and drops any grant in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_d_q  <= 1'b0;
            i_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            i_ack_q   <= i_ack_d;
            i_err_q   <= i_err_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Latched request fields; only observed while granted, so no reset needed.
    always_ff @(posedge CLK) begin
        lat_wen_q   <= lat_wen_d;
        lat_addr_q  <= lat_addr_d;
        lat_wdata_q <= lat_wdata_d;
    end

    // RAM port is driven only while a grant is held; all zero in IDLE.
    always_comb begin
        granted       = (state_q != IDLE);
        bus.ram_ren   = granted & ~lat_wen_q;
        bus.ram_wen   = granted & lat_wen_q;
        bus.ram_addr  = granted ? {lat_addr_q, 2'b00} : 16'd0;
        bus.ram_store = granted ? lat_wdata_q : 32'd0;
        bus.i_ack     = i_ack_q;
        bus.i_err     = i_err_q;
        bus.i_rdata   = i_rdata_q;
        bus.d_ack     = d_ack_q;
        bus.d_err     = d_err_q;
        bus.d_rdata   = d_rdata_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses, a monitor pops and
// compares on every ack/err pulse, and a small RAM responder answers with scripted latency.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus ();
    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        bit          d;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    // RAM responder configuration and observations
    int          lat_cfg   = 0;      // BUSY cycles before answering; -1 = stuck BUSY
    bit          err_mode  = 1'b0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_load = 32'h0;
    int          rcnt      = 0;
    int          act_cnt   = 0;
    logic [15:0] first_addr;
    logic [31:0] first_store;
    logic        first_ren, first_wen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit d, input bit err, input logic [31:0] rdata);
        exp_t e;
        e.d = d; e.err = err; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // RAM model: answers on the lat_cfg-th active cycle, returns address-tagged data.
    always @(negedge CLK) begin
        if (bus.ram_ren || bus.ram_wen) begin
            if (rcnt == 0) begin
                first_addr  = bus.ram_addr;
                first_store = bus.ram_store;
                first_ren   = bus.ram_ren;
                first_wen   = bus.ram_wen;
                act_cnt     = 0;
            end else begin
                check("ram_addr_stable", {16'h0, bus.ram_addr}, {16'h0, first_addr});
            end
            check("ren_wen_excl", {31'h0, bus.ram_ren & bus.ram_wen}, 32'h0);
            act_cnt++;
            if (lat_cfg >= 0 && rcnt == lat_cfg)
                bus.ram_state = err_mode ? 2'd3 : 2'd2;
            else
                bus.ram_state = 2'd1;
            bus.ram_load = use_fixed ? fixed_load : {16'hA5A5, bus.ram_addr};
            rcnt++;
        end else begin
            bus.ram_state = 2'd0;
            bus.ram_load  = 32'h0;
            rcnt = 0;
        end
    end

    // Monitor: every response pulse is matched against the head of the scoreboard.
    always @(negedge CLK) begin
        int   n;
        exp_t e;
        logic got_d, got_err;
        if (mon_en) begin
            n = int'(bus.i_ack) + int'(bus.i_err) + int'(bus.d_ack) + int'(bus.d_err);
            if (n > 1) check("single_resp", n, 1);
            if (n != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", n, 0);
                end else begin
                    e = exp_q.pop_front();
                    got_d   = bus.d_ack | bus.d_err;
                    got_err = bus.i_err | bus.d_err;
                    check("resp_side", {31'h0, got_d}, {31'h0, e.d});
                    check("resp_err", {31'h0, got_err}, {31'h0, e.err});
                    check("resp_rdata", got_d ? bus.d_rdata : bus.i_rdata, e.rdata);
                end
            end
        end
    end

    // Waits for the next response pulse, releases that side's request, returns cycles waited.
    task automatic wait_resp(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (bus.d_ack || bus.d_err) begin
                bus.d_req = 1'b0;
                cyc = k;
                return;
            end
            if (bus.i_ack || bus.i_err) begin
                bus.i_req = 1'b0;
                cyc = k;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL wait_resp: no response within 60 cycles at %0t", $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_wen = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ram_state = 2'd0; bus.ram_load = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_i_ack", {31'h0, bus.i_ack}, 0);
        check("rst_i_err", {31'h0, bus.i_err}, 0);
        check("rst_d_ack", {31'h0, bus.d_ack}, 0);
        check("rst_d_err", {31'h0, bus.d_err}, 0);
        check("rst_ram_ren", {31'h0, bus.ram_ren}, 0);
        check("rst_ram_wen", {31'h0, bus.ram_wen}, 0);
        check("rst_ram_addr", {16'h0, bus.ram_addr}, 0);
        check("rst_ram_store", bus.ram_store, 0);
        check("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
        RST = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);

        // First tie after reset: D wins in both builds, then I
        lat_cfg = 1; err_mode = 0; use_fixed = 0;
        push(1, 0, 32'hA5A50800);
        push(0, 0, 32'hA5A50400);
        bus.i_addr = 14'h0100; bus.d_addr = 14'h0200; bus.d_wen = 0;
        bus.i_req = 1; bus.d_req = 1;
        wait_resp(cyc);
        check("tie1_first_lat", cyc, 3);
        wait_resp(cyc);
        check("tie1_second_lat", cyc, 3);
        repeat (2) @(negedge CLK);

        // I read, 3 BUSY then ACCESS
        lat_cfg = 3; use_fixed = 1; fixed_load = 32'hDEADBEEF;
        push(0, 0, 32'hDEADBEEF);
        bus.i_addr = 14'h1A2B; bus.i_req = 1;
        wait_resp(cyc);
        check("iread_lat", cyc, 5);
        check("iread_ren_cycles", act_cnt, 4);
        check("iread_addr", {16'h0, first_addr}, 32'h000068AC);
        check("iread_ren", {31'h0, first_ren}, 1);
        check("iread_wen", {31'h0, first_wen}, 0);
        repeat (2) @(negedge CLK);

        // D write, immediate ACCESS
        lat_cfg = 0; use_fixed = 1; fixed_load = 32'hFFFFFFFF;
        push(1, 0, 32'h0);
        bus.d_addr = 14'h0010; bus.d_wdata = 32'h12345678; bus.d_wen = 1; bus.d_req = 1;
        wait_resp(cyc);
        bus.d_wen = 0;
        check("dwrite_lat", cyc, 2);
        check("dwrite_cycles", act_cnt, 1);
        check("dwrite_wen", {31'h0, first_wen}, 1);
        check("dwrite_ren", {31'h0, first_ren}, 0);
        check("dwrite_addr", {16'h0, first_addr}, 32'h00000040);
        check("dwrite_store", first_store, 32'h12345678);
        repeat (2) @(negedge CLK);

        // Tie after a D grant: fixed priority gives D again, round-robin gives I
        lat_cfg = 1; use_fixed = 0;
`ifdef MEM_ARB_RR_EN
        push(0, 0, 32'hA5A50400);
        push(1, 0, 32'hA5A50800);
`else
        push(1, 0, 32'hA5A50800);
        push(0, 0, 32'hA5A50400);
`endif
        bus.i_addr = 14'h0100; bus.d_addr = 14'h0200;
        bus.i_req = 1; bus.d_req = 1;
        wait_resp(cyc);
        wait_resp(cyc);
        repeat (2) @(negedge CLK);

        // Timeout: RAM stuck BUSY, d_err on the 5th cycle after the grant decision
        lat_cfg = -1;
        push(1, 1, 32'h0);
        bus.d_addr = 14'h0007; bus.d_req = 1;
        wait_resp(cyc);
        check("timeout_lat", cyc, 5);
        check("timeout_ren_cycles", act_cnt, 4);
        repeat (2) @(negedge CLK);

        // RAM ERROR on an I read
        lat_cfg = 1; err_mode = 1;
        push(0, 1, 32'h0);
        bus.i_addr = 14'h0005; bus.i_req = 1;
        wait_resp(cyc);
        check("error_lat", cyc, 3);
        err_mode = 0;
        repeat (2) @(negedge CLK);

        // Requester drops req and changes fields mid-grant: original transaction completes
        lat_cfg = 3;
        push(1, 0, 32'hA5A500CC);
        bus.d_addr = 14'h0033; bus.d_wen = 0; bus.d_req = 1;
        @(negedge CLK);
        bus.d_req = 0; bus.d_addr = 14'h3FFF; bus.d_wen = 1;
        wait_resp(cyc);
        check("drop_lat", cyc, 4);
        check("drop_addr", {16'h0, first_addr}, 32'h000000CC);
        bus.d_wen = 0;
        repeat (2) @(negedge CLK);

        // Reset mid-grant: port released next cycle, no response ever
        lat_cfg = -1;
        bus.i_addr = 14'h0022; bus.i_req = 1;
        @(negedge CLK);
        check("rstmid_ren_before", {31'h0, bus.ram_ren}, 1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rstmid_ren_after", {31'h0, bus.ram_ren}, 0);
        check("rstmid_addr_after", {16'h0, bus.ram_addr}, 0);
        RST = 1'b0; bus.i_req = 0;
        repeat (8) @(negedge CLK);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
